rf_wb_arbiter: RTL and testbench

Shares the register file's single write port (write-enable, 4-bit address, 16-bit data) between two write-back requesters: A (ALU result) and M (memory load). Each requester has a one-entry holding register behind a valid/ready handshake, and arbitration is oldest-first. A 16-bit pending-write scoreboard lets decode stall any instruction that reads a register with an outstanding write. The block sits between the execute/memory stages and the register file write port.

---
 rtl/rf_wb_arbiter_pkg.sv | 19 +
 rtl/rf_wb_arbiter_if.sv | 45 ++++
 rtl/rf_wb_hold.sv | 68 ++++++
 rtl/rf_wb_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared constants and types for the register-file write-back arbiter.
//   DW / AW   : data and register address widths
//   NumRegs   : register count (one scoreboard bit each)
//   R0Idx     : index of the hard-wired zero register
//   req_e     : requester identifier for the round-robin pointer and the age bit
package rf_wb_arbiter_pkg;

  localparam int unsigned DW      = 16;
  localparam int unsigned AW      = 4;
  localparam int unsigned NumRegs = 16;

  localparam logic [AW-1:0] R0Idx = '0;

  typedef enum logic {
    ReqA = 1'b0,
    ReqM = 1'b1
  } req_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: bundles the write-back request handshakes, the decode scoreboard
// lookup and the register-file write port.
//   a_* / m_*           : ALU and load write-back requests (valid/ready, addr, data)
//   chk_rs / chk_rt     : decode source registers; rs_busy / rt_busy report pending writes
//   busy_vec            : pending-write bit per register
//   rf_we/waddr/wdata   : registered register-file write port
//   conflict_cnt        : saturating count of cycles with both holds valid
// master = requester/decode side, slave = arbiter.
interface rf_wb_arbiter_if
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned CntW = 16
) ();

  logic               a_valid;
  logic               a_ready;
  logic [AW-1:0]      a_addr;
  logic [DW-1:0]      a_data;
  logic               m_valid;
  logic               m_ready;
  logic [AW-1:0]      m_addr;
  logic [DW-1:0]      m_data;
  logic [AW-1:0]      chk_rs;
  logic [AW-1:0]      chk_rt;
  logic               rs_busy;
  logic               rt_busy;
  logic [NumRegs-1:0] busy_vec;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic [CntW-1:0]    conflict_cnt;

  modport master (
    output a_valid, a_addr, a_data, m_valid, m_addr, m_data, chk_rs, chk_rt,
    input  a_ready, m_ready, rs_busy, rt_busy, busy_vec, rf_we, rf_waddr, rf_wdata,
           conflict_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, m_valid, m_addr, m_data, chk_rs, chk_rt,
    output a_ready, m_ready, rs_busy, rt_busy, busy_vec, rf_we, rf_waddr, rf_wdata,
           conflict_cnt
  );

endinterface

// File: rtl/rf_wb_hold.sv
// rf_wb_hold: one-entry holding register for a single write-back requester.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   valid_i / ready_o  : request handshake (ready forced low during reset)
//   addr_i, data_i     : destination register and write data
//   grant_i            : arbiter retires the held entry at the next edge
//   hold_v_o, hold_addr_o, hold_data_o : current held entry
//   capture_o          : a real (non-R0) entry is captured at the next edge
module rf_wb_hold
  import rf_wb_arbiter_pkg::*;
#(
  parameter bit ProtectR0 = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] data_i,
  input  logic          grant_i,
  output logic          hold_v_o,
  output logic [AW-1:0] hold_addr_o,
  output logic [DW-1:0] hold_data_o,
  output logic          capture_o
);

  logic          hold_v_q, hold_v_d;
  logic [AW-1:0] hold_addr_q, hold_addr_d;
  logic [DW-1:0] hold_data_q, hold_data_d;
  logic          xfer;
  logic          drop;

  // Ready when empty or when the entry leaves this edge: one transfer per cycle.
  assign ready_o   = ~rst_i & (~hold_v_q | grant_i);
  assign xfer      = valid_i & ready_o;
  // R0 writes complete the handshake but never occupy the hold.
  assign drop      = ProtectR0 && (addr_i == R0Idx);
  assign capture_o = xfer & ~drop;

  always_comb begin
    hold_v_d    = hold_v_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    if (capture_o) begin
      hold_v_d    = 1'b1;
      hold_addr_d = addr_i;
      hold_data_d = data_i;
    end else if (grant_i) begin
      hold_v_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_v_q    <= 1'b0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

  assign hold_v_o    = hold_v_q;
  assign hold_addr_o = hold_addr_q;
  assign hold_data_o = hold_data_q;

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register file's single write port between the ALU (A) and
// load (M) write-back paths. Each path has a one-entry hold; arbitration is oldest-first
// with a round-robin tie-break for holds captured at the same edge. A pending-write
// scoreboard lets decode stall on outstanding writes.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus          : rf_wb_arbiter_if slave modport (requests, scoreboard, write port, counter)
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter bit          ProtectR0 = 1'b1,
  parameter int unsigned CntW      = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rf_wb_arbiter_if.slave bus
);

  logic          hv_a, hv_m;
  logic [AW-1:0] ha_addr, hm_addr;
  logic [DW-1:0] ha_data, hm_data;
  logic          cap_a, cap_m;
  logic          grant_a, grant_m;
  logic          both;
  req_e          sel;

  req_e rr_q, rr_d;
  req_e age_q, age_d;   // which hold was captured first
  logic same_q, same_d; // both current holds were captured at the same edge

  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [NumRegs-1:0] busy;

  rf_wb_hold #(
    .ProtectR0 (ProtectR0)
  ) u_hold_a (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (bus.a_valid),
    .ready_o     (bus.a_ready),
    .addr_i      (bus.a_addr),
    .data_i      (bus.a_data),
    .grant_i     (grant_a),
    .hold_v_o    (hv_a),
    .hold_addr_o (ha_addr),
    .hold_data_o (ha_data),
    .capture_o   (cap_a)
  );

  rf_wb_hold #(
    .ProtectR0 (ProtectR0)
  ) u_hold_m (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (bus.m_valid),
    .ready_o     (bus.m_ready),
    .addr_i      (bus.m_addr),
    .data_i      (bus.m_data),
    .grant_i     (grant_m),
    .hold_v_o    (hv_m),
    .hold_addr_o (hm_addr),
    .hold_data_o (hm_data),
    .capture_o   (cap_m)
  );

  // Arbitration
  assign both    = hv_a & hv_m;
  assign sel     = same_q ? rr_q : age_q;
  assign grant_a = hv_a & (~hv_m | (sel == ReqA));
  assign grant_m = hv_m & (~hv_a | (sel == ReqM));

  always_comb begin
    rr_d   = rr_q;
    age_d  = age_q;
    same_d = same_q;
    if (both && same_q) begin
      rr_d = (rr_q == ReqA) ? ReqM : ReqA;
    end
    // A lone capture is younger than whatever the other hold keeps; if the other hold
    // empties the age bit is simply unused until the next capture.
    if (cap_a && cap_m) begin
      same_d = 1'b1;
    end else if (cap_a) begin
      same_d = 1'b0;
      age_d  = ReqM;
    end else if (cap_m) begin
      same_d = 1'b0;
      age_d  = ReqA;
    end
  end

  // Write-port register: addr/data hold their last value when idle.
  always_comb begin
    rf_we_d    = grant_a | grant_m;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant_a) begin
      rf_waddr_d = ha_addr;
      rf_wdata_d = ha_data;
    end else if (grant_m) begin
      rf_waddr_d = hm_addr;
      rf_wdata_d = hm_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (both && (cnt_q != {CntW{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q       <= ReqA;
      age_q      <= ReqA;
      same_q     <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      cnt_q      <= '0;
    end else begin
      rr_q       <= rr_d;
      age_q      <= age_d;
      same_q     <= same_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      cnt_q      <= cnt_d;
    end
  end

  // Scoreboard; the rf_we term covers the register file's falling-edge write window.
  always_comb begin
    busy = '0;
    for (int r = 0; r < NumRegs; r++) begin
      busy[r] = (hv_a && (ha_addr == AW'(r))) || (hv_m && (hm_addr == AW'(r))) ||
                (rf_we_q && (rf_waddr_q == AW'(r)));
    end
  end

  assign bus.busy_vec     = busy;
  assign bus.rs_busy      = busy[bus.chk_rs];
  assign bus.rt_busy      = busy[bus.chk_rt];
  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed-vector bench for rf_wb_arbiter with hand-computed expectations.
module tb_rf_wb_arbiter;
  import rf_wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.CntW(16)) bus ();

  rf_wb_arbiter #(
    .ProtectR0 (1'b1),
    .CntW      (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.a_valid = v;
    bus.a_addr  = ad;
    bus.a_data  = d;
  endtask

  task automatic drv_m(input logic v, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    bus.m_valid = v;
    bus.m_addr  = ad;
    bus.m_data  = d;
  endtask

  task automatic check_wr(input string tag, input logic [AW-1:0] ad, input logic [DW-1:0] d);
    check({tag, ".we"}, 32'(bus.rf_we), 32'd1);
    check({tag, ".waddr"}, 32'(bus.rf_waddr), 32'(ad));
    check({tag, ".wdata"}, 32'(bus.rf_wdata), 32'(d));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requests asserted
    drv_a(1'b1, 4'd1, 16'h0011);
    drv_m(1'b1, 4'd2, 16'h0022);
    bus.chk_rs = '0;
    bus.chk_rt = '0;
    #1;
    check("rst.a_ready", 32'(bus.a_ready), 32'd0);
    check("rst.m_ready", 32'(bus.m_ready), 32'd0);
    tick();
    tick();
    check("rst.a_ready2", 32'(bus.a_ready), 32'd0);
    check("rst.rf_we", 32'(bus.rf_we), 32'd0);
    rst = 1'b0;
    drv_a(1'b0, 4'd0, 16'h0);
    drv_m(1'b0, 4'd0, 16'h0);
    #1;
    check("rel.a_ready", 32'(bus.a_ready), 32'd1);
    check("rel.m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    check("rel.rf_we", 32'(bus.rf_we), 32'd0);
    check("rel.busy", 32'(bus.busy_vec), 32'h0);
    check("rel.cnt", 32'(bus.conflict_cnt), 32'd0);

    // Single A write
    drv_a(1'b1, 4'd5, 16'h1234);
    bus.chk_rs = 4'd5;
    #1;
    check("a1.rs_busy0", 32'(bus.rs_busy), 32'd0);
    tick();
    drv_a(1'b0, 4'd0, 16'h0);
    check("a1.busy_hold", 32'(bus.busy_vec), 32'h0020);
    check("a1.rs_busy1", 32'(bus.rs_busy), 32'd1);
    check("a1.we_early", 32'(bus.rf_we), 32'd0);
    tick();
    check_wr("a1.wr", 4'd5, 16'h1234);
    check("a1.busy_we", 32'(bus.busy_vec), 32'h0020);
    tick();
    check("a1.we_off", 32'(bus.rf_we), 32'd0);
    check("a1.busy_clr", 32'(bus.busy_vec), 32'h0);
    check("a1.rs_busy2", 32'(bus.rs_busy), 32'd0);
    check("a1.wdata_keep", 32'(bus.rf_wdata), 32'h1234);

    // Same-edge conflict, pointer at A
    bus.chk_rt = 4'd3;
    drv_a(1'b1, 4'd3, 16'hAAAA);
    drv_m(1'b1, 4'd3, 16'hBBBB);
    tick();
    drv_a(1'b0, 4'd0, 16'h0);
    drv_m(1'b0, 4'd0, 16'h0);
    check("t1.busy", 32'(bus.busy_vec), 32'h0008);
    check("t1.rt_busy", 32'(bus.rt_busy), 32'd1);
    check("t1.a_ready", 32'(bus.a_ready), 32'd1);
    check("t1.m_ready", 32'(bus.m_ready), 32'd0);
    tick();
    check_wr("t1.first", 4'd3, 16'hAAAA);
    check("t1.cnt", 32'(bus.conflict_cnt), 32'd1);
    tick();
    check_wr("t1.second", 4'd3, 16'hBBBB);
    tick();
    check("t1.we_off", 32'(bus.rf_we), 32'd0);
    check("t1.last", 32'(bus.rf_wdata), 32'hBBBB);
    check("t1.rt_busy0", 32'(bus.rt_busy), 32'd0);

    // Second tie: pointer now at M
    drv_a(1'b1, 4'd4, 16'h1111);
    drv_m(1'b1, 4'd4, 16'h2222);
    tick();
    drv_a(1'b0, 4'd0, 16'h0);
    drv_m(1'b0, 4'd0, 16'h0);
    check("t2.m_ready", 32'(bus.m_ready), 32'd1);
    check("t2.a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    check_wr("t2.first", 4'd4, 16'h2222);
    check("t2.cnt", 32'(bus.conflict_cnt), 32'd2);
    tick();
    check_wr("t2.second", 4'd4, 16'h1111);
    tick();
    check("t2.we_off", 32'(bus.rf_we), 32'd0);

    // Age ordering: after a tie (pointer A -> M), refills alternate and the older hold wins
    drv_a(1'b1, 4'd1, 16'hA0A0);
    drv_m(1'b1, 4'd2, 16'hB0B0);
    tick();
    drv_a(1'b1, 4'd3, 16'hA1A1);
    drv_m(1'b0, 4'd0, 16'h0);
    check("age.e0_a_ready", 32'(bus.a_ready), 32'd1);
    check("age.e0_m_ready", 32'(bus.m_ready), 32'd0);
    tick();
    check_wr("age.w0", 4'd1, 16'hA0A0);
    drv_a(1'b0, 4'd0, 16'h0);
    drv_m(1'b1, 4'd4, 16'hB1B1);
    check("age.e1_a_ready", 32'(bus.a_ready), 32'd0);
    check("age.e1_m_ready", 32'(bus.m_ready), 32'd1);
    tick();
    check_wr("age.w1", 4'd2, 16'hB0B0);
    drv_m(1'b0, 4'd0, 16'h0);
    check("age.e2_a_ready", 32'(bus.a_ready), 32'd1);
    check("age.e2_m_ready", 32'(bus.m_ready), 32'd0);
    tick();
    check_wr("age.w2", 4'd3, 16'hA1A1);
    check("age.cnt", 32'(bus.conflict_cnt), 32'd5);
    tick();
    check_wr("age.w3", 4'd4, 16'hB1B1);
    tick();
    check("age.we_off", 32'(bus.rf_we), 32'd0);

    // Back-to-back M stream, one write per cycle
    drv_m(1'b1, 4'd5, 16'hC0C0);
    tick();
    drv_m(1'b1, 4'd6, 16'hC1C1);
    check("str.ready0", 32'(bus.m_ready), 32'd1);
    tick();
    check_wr("str.w0", 4'd5, 16'hC0C0);
    drv_m(1'b1, 4'd7, 16'hC2C2);
    check("str.ready1", 32'(bus.m_ready), 32'd1);
    tick();
    check_wr("str.w1", 4'd6, 16'hC1C1);
    drv_m(1'b0, 4'd0, 16'h0);
    tick();
    check_wr("str.w2", 4'd7, 16'hC2C2);
    tick();
    check("str.we_off", 32'(bus.rf_we), 32'd0);
    check("str.cnt", 32'(bus.conflict_cnt), 32'd5);

    // R0 discard
    drv_a(1'b1, 4'd0, 16'hFFFF);
    #1;
    check("r0.a_ready", 32'(bus.a_ready), 32'd1);
    tick();
    drv_a(1'b0, 4'd0, 16'h0);
    check("r0.busy", 32'(bus.busy_vec), 32'h0);
    check("r0.we0", 32'(bus.rf_we), 32'd0);
    tick();
    check("r0.we1", 32'(bus.rf_we), 32'd0);
    check("r0.wdata", 32'(bus.rf_wdata), 32'hC2C2);

    // Reset mid-operation (pointer at M after the age sequence)
    drv_a(1'b1, 4'd10, 16'hD0D0);
    drv_m(1'b1, 4'd11, 16'hD1D1);
    tick();
    drv_a(1'b0, 4'd0, 16'h0);
    drv_m(1'b1, 4'd13, 16'hD3D3);
    check("mid.m_ready", 32'(bus.m_ready), 32'd1);
    check("mid.a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    drv_m(1'b0, 4'd0, 16'h0);
    check_wr("mid.wr", 4'd11, 16'hD1D1);
    check("mid.busy", 32'(bus.busy_vec), 32'h2C00);
    check("mid.cnt", 32'(bus.conflict_cnt), 32'd6);
    rst = 1'b1;
    #1;
    check("mid.rst_a_ready", 32'(bus.a_ready), 32'd0);
    tick();
    check("mid.rst_we", 32'(bus.rf_we), 32'd0);
    check("mid.rst_busy", 32'(bus.busy_vec), 32'h0);
    check("mid.rst_cnt", 32'(bus.conflict_cnt), 32'd0);
    check("mid.rst_waddr", 32'(bus.rf_waddr), 32'd0);
    check("mid.rst_wdata", 32'(bus.rf_wdata), 32'd0);
    rst = 1'b0;
    tick();
    check("mid.post_we0", 32'(bus.rf_we), 32'd0);
    tick();
    check("mid.post_we1", 32'(bus.rf_we), 32'd0);
    check("mid.post_busy", 32'(bus.busy_vec), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
